// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: per-key debounce, key codes queued in a small FIFO for a keyReady/rdn consumer.
// Latency: a press is queued in the EVAL of its DEBOUNCE-th frame; a full FIFO drops new presses and sets overflow.
module keypad_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row_n,
    output logic [3:0] key_col_n,
    input  logic       rdn,
    output logic       keyReady,
    output logic [4:0] keyCode,
    output logic       overflow
);

    localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW   = 3;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    typedef enum logic {
        SCAN,
        EVAL
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [3:0]           idx_q, idx_d;
    logic [15:0]          snap_q, snap_d;
    logic [15:0]          deb_q, deb_d;
    logic [15:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]           row_s1_q, row_s2_q;
    logic                 push_vld;

    logic [FIFO_DEPTH-1:0][3:0] mem_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]            count_q;
    logic                       popped_q;
    logic                       overflow_q;
    logic                       pop, full, do_push, drop;

    // Rows are asynchronous to clk; the 2-FF stage settles them before sampling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= key_row_n;
            row_s2_q <= row_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            col_q   <= '0;
            dwell_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dwell_d   = dwell_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        push_vld  = 1'b0;
        key_col_n = 4'b1111;
        case (state_q)
            SCAN: begin
                key_col_n = ~(4'b0001 << col_q);
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    for (int r = 0; r < 4; r++) begin
                        snap_d[4*r + int'(col_q)] = ~row_s2_q[r];
                    end
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = EVAL;
                        idx_d   = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            EVAL: begin
                // One key per cycle keeps the debounce logic to a single shared comparator.
                if (snap_q[idx_q] == deb_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] == CW'(DEBOUNCE - 1)) begin
                    deb_d[idx_q] = ~deb_q[idx_q];
                    cnt_d[idx_q] = '0;
                    push_vld     = snap_q[idx_q];
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = SCAN;
                    col_d   = '0;
                    dwell_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign pop     = rdn && (count_q != '0);
    assign full    = (count_q == CNTW'(FIFO_DEPTH));
    assign do_push = push_vld && (!full || pop);
    assign drop    = push_vld && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            popped_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= idx_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - CNTW'(1);
            end
            popped_q <= pop;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Dropping keyReady for a cycle after each pop gives the consumer a fresh rising edge per code.
    assign keyReady = (count_q != '0) && !popped_q;
    assign keyCode  = (count_q != '0) ? {1'b0, mem_q[rd_ptr_q]} : 5'd0;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: frame-level reference model plus directed vectors and corner sequences.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int DEPTH    = 4;
    localparam int FRAME    = 32;

    logic        clk, rst, rdn;
    logic [3:0]  key_row_n, key_col_n;
    logic        keyReady, overflow;
    logic [4:0]  keyCode;
    logic [15:0] pressed;

    int checks   = 0;
    int failures = 0;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .key_row_n(key_row_n), .key_col_n(key_col_n),
        .rdn(rdn), .keyReady(keyReady), .keyCode(keyCode), .overflow(overflow)
    );

    // Physical keypad: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        key_row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col_n[c]) key_row_n[r] = 1'b0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycle position within the 32-cycle frame, per-key debounce, code queue.
    int mt;
    bit mdeb[16];
    int mcnt[16];
    int q[$];
    bit movf, mpopped;

    task automatic model_reset();
        mt = 0; movf = 0; mpopped = 0; q.delete();
        for (int i = 0; i < 16; i++) begin mdeb[i] = 0; mcnt[i] = 0; end
    endtask

    task automatic model_edge(input logic r);
        bit pop, push, s;
        int key;
        pop = r && (q.size() > 0);
        push = 0; key = 0;
        if (mt >= 16) begin
            key = mt - 16;
            s = pressed[key];
            if (s == mdeb[key]) mcnt[key] = 0;
            else begin
                mcnt[key]++;
                if (mcnt[key] == DEB) begin
                    mdeb[key] = s; mcnt[key] = 0; push = s;
                end
            end
        end
        if (pop) q.delete(0);
        if (push) begin
            if (q.size() < DEPTH) q.push_back(key);
            else movf = 1;
        end
        mpopped = pop;
        mt = (mt + 1) % FRAME;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] ec;
        ec = 4'hF;
        if (mt < 16) ec[mt/4] = 1'b0;
        chk("col", key_col_n, ec);
        chk("ready", keyReady, (q.size() > 0) && !mpopped);
        chk("code", keyCode, (q.size() > 0) ? q[0] : 0);
        chk("ovf", overflow, movf);
    endtask

    task automatic cycle(input logic r);
        rdn = r;
        @(posedge clk);
        model_edge(r);
        #1;
        rdn = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0; rdn = 1'b0;
        #2;
        chk("rst_col", key_col_n, 4'b1110);
        chk("rst_ready", keyReady, 0);
        chk("rst_code", keyCode, 0);
        chk("rst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] mask;
        int          frames;
        logic        rdy;
        logic [4:0]  code;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        rst = 1'b1; rdn = 1'b0; pressed = '0;
        model_reset();
        #1;

        vecs[0] = '{16'h0000, 2, 1'b0, 5'h00, 1'b0};
        vecs[1] = '{16'h1000, 2, 1'b1, 5'h0C, 1'b0};
        vecs[2] = '{16'h0020, 1, 1'b0, 5'h00, 1'b0};
        vecs[3] = '{16'h2020, 2, 1'b1, 5'h05, 1'b0};
        vecs[4] = '{16'h003E, 2, 1'b1, 5'h01, 1'b1};
        vecs[5] = '{16'h8000, 3, 1'b1, 5'h0F, 1'b0};
        for (int v = 0; v < 6; v++) begin
            pressed = vecs[v].mask;
            do_reset();
            run(vecs[v].frames * FRAME);
            chk($sformatf("vec%0d_ready", v), keyReady, vecs[v].rdy);
            chk($sformatf("vec%0d_code", v), keyCode, vecs[v].code);
            chk($sformatf("vec%0d_ovf", v), overflow, vecs[v].ovf);
        end

        // Key 12 held: ready rises just after EVAL cycle 12 of frame 2, one push only.
        pressed = 16'h1000;
        do_reset();
        run(FRAME + 28);
        chk("k12_before", keyReady, 0);
        run(1);
        chk("k12_ready", keyReady, 1);
        chk("k12_code", keyCode, 5'h0C);
        run(3 + FRAME);
        pressed = '0;
        run(2 * FRAME);
        pressed = 16'h1000;
        run(2 * FRAME);
        chk("k12_depth", q.size(), 2);
        cycle(1'b1);
        chk("k12_pop_low", keyReady, 0);
        run(1);
        chk("k12_second", keyCode, 5'h0C);
        chk("k12_second_rdy", keyReady, 1);
        cycle(1'b1);

        // Single-frame bounce twice in a row never debounces.
        pressed = 16'h0020;
        do_reset();
        run(FRAME);
        pressed = '0;
        run(FRAME);
        pressed = 16'h0020;
        run(FRAME);
        pressed = '0;
        run(FRAME);
        chk("bounce_ready", keyReady, 0);

        // Two simultaneous keys, consumer handshake.
        pressed = 16'h2020;
        do_reset();
        n = 0;
        while (!keyReady && n < 100) begin cycle(1'b0); n++; end
        chk("hs_wait_ready", int'(n < 100), 1);
        chk("hs_first", keyCode, 5'h05);
        while (mt != 0) cycle(1'b0);
        run(3);
        cycle(1'b1);
        chk("hs_gap", keyReady, 0);
        run(1);
        chk("hs_second_rdy", keyReady, 1);
        chk("hs_second", keyCode, 5'h0D);
        cycle(1'b1);
        chk("hs_empty", keyReady, 0);
        cycle(1'b1);
        chk("hs_underflow", keyCode, 0);

        // Overflow: five keys, four slots; drain and confirm overflow sticks.
        pressed = 16'h8249;
        do_reset();
        run(2 * FRAME);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", keyCode, 5'h00);
        cycle(1'b1); run(1); chk("ovf_h1", keyCode, 5'h03);
        cycle(1'b1); run(1); chk("ovf_h2", keyCode, 5'h06);
        cycle(1'b1); run(1); chk("ovf_h3", keyCode, 5'h09);
        cycle(1'b1); run(1);
        chk("ovf_drained", keyReady, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-EVAL with two codes queued.
        pressed = 16'h0084;
        do_reset();
        run(2 * FRAME + 20);
        chk("mid_depth", q.size(), 2);
        rst = 1'b0;
        #2;
        chk("mid_rst_ready", keyReady, 0);
        chk("mid_rst_col", key_col_n, 4'b1110);
        chk("mid_rst_code", keyCode, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        run(FRAME);
        chk("mid_frame1", keyReady, 0);
        run(FRAME);
        chk("mid_repush", keyCode, 5'h02);
        chk("mid_repush_depth", q.size(), 2);

        // Randomized keys (changed only at frame boundaries) and random reads.
        pressed = '0;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) pressed[i] = ($urandom_range(0, 7) == 0);
            end
            for (int k = 0; k < FRAME; k++) cycle($urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
